// File: rtl/ghost_mode_ctrl_if.sv
// Control bundle between the game logic and the ghost mode sequencer.
// The slave side is the sequencer; the master side drives game events and observes ghost mode.
interface ghost_mode_ctrl_if;
  logic       start;
  logic       freeze;
  logic       energizer;
  logic       levelRestart;
  logic       isScatter;
  logic       isChase;
  logic       isFrightened;
  logic       isFlashing;
  logic       reverseReq;
  logic [2:0] phase;

  modport master (
    output start, freeze, energizer, levelRestart,
    input  isScatter, isChase, isFrightened, isFlashing, reverseReq, phase
  );

  modport slave (
    input  start, freeze, energizer, levelRestart,
    output isScatter, isChase, isFrightened, isFlashing, reverseReq, phase
  );
endinterface

// File: rtl/ghost_mode_ctrl.sv
// Global ghost behaviour sequencer: level-1 scatter/chase schedule, energizer fright periods
// that freeze the schedule, and a one-cycle reverse request on every mode change.
module ghost_mode_ctrl #(
  parameter int SEC_TICKS       = 25_000_000,
  parameter int SCATTER_LONG_S  = 7,
  parameter int SCATTER_SHORT_S = 5,
  parameter int CHASE_S         = 20,
  parameter int FRIGHT_S        = 6,
  parameter int FLASH_S         = 2
) (
  input logic clk,
  input logic reset_n,
  ghost_mode_ctrl_if.slave bus
);

  localparam int CW = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FRIGHT = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] secCnt;
  logic [7:0]    phaseSec;
  logic [7:0]    frightSec;
  logic [2:0]    phaseQ;
  logic          isScatterQ;
  logic          isChaseQ;
  logic          isFrightenedQ;
  logic          isFlashingQ;
  logic          reverseReqQ;
  logic          secTick;

  function automatic logic [7:0] phaseLen(input logic [2:0] p);
    case (p)
      3'd0, 3'd2: return 8'(SCATTER_LONG_S);
      3'd4, 3'd6: return 8'(SCATTER_SHORT_S);
      default:    return 8'(CHASE_S);
    endcase
  endfunction

  assign secTick = (secCnt == CW'(SEC_TICKS - 1));

  // Priority: start low, then levelRestart, then freeze, then energizer, then timers.
  // Phase 7 never advances, so its second counter simply stops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || !bus.start) begin
      state         <= IDLE;
      secCnt        <= '0;
      phaseSec      <= '0;
      frightSec     <= '0;
      phaseQ        <= '0;
      isScatterQ    <= 1'b0;
      isChaseQ      <= 1'b0;
      isFrightenedQ <= 1'b0;
      isFlashingQ   <= 1'b0;
      reverseReqQ   <= 1'b0;
    end else if (state == IDLE || bus.levelRestart) begin
      state         <= RUN;
      secCnt        <= '0;
      phaseSec      <= '0;
      frightSec     <= '0;
      phaseQ        <= '0;
      isScatterQ    <= 1'b1;
      isChaseQ      <= 1'b0;
      isFrightenedQ <= 1'b0;
      isFlashingQ   <= 1'b0;
      reverseReqQ   <= 1'b0;
    end else if (bus.freeze) begin
      reverseReqQ <= 1'b0;
    end else if (bus.energizer) begin
      state         <= FRIGHT;
      secCnt        <= '0;
      frightSec     <= '0;
      isScatterQ    <= 1'b0;
      isChaseQ      <= 1'b0;
      isFrightenedQ <= 1'b1;
      isFlashingQ   <= 1'b0;
      reverseReqQ   <= (state == RUN);
    end else begin
      reverseReqQ <= 1'b0;
      secCnt      <= secTick ? '0 : secCnt + CW'(1);
      if (state == RUN) begin
        if (secTick && phaseQ != 3'd7) begin
          if (phaseSec == phaseLen(phaseQ) - 8'd1) begin
            phaseQ      <= phaseQ + 3'd1;
            phaseSec    <= '0;
            isScatterQ  <= ~isScatterQ;
            isChaseQ    <= ~isChaseQ;
            reverseReqQ <= 1'b1;
          end else begin
            phaseSec <= phaseSec + 8'd1;
          end
        end
      end else if (secTick) begin
        if (frightSec == 8'(FRIGHT_S - 1)) begin
          state         <= RUN;
          frightSec     <= '0;
          isFrightenedQ <= 1'b0;
          isFlashingQ   <= 1'b0;
          isScatterQ    <= ~phaseQ[0];
          isChaseQ      <= phaseQ[0];
        end else begin
          frightSec   <= frightSec + 8'd1;
          isFlashingQ <= ((frightSec + 8'd1) >= 8'(FRIGHT_S - FLASH_S));
        end
      end
    end
  end

  assign bus.isScatter    = isScatterQ;
  assign bus.isChase      = isChaseQ;
  assign bus.isFrightened = isFrightenedQ;
  assign bus.isFlashing   = isFlashingQ;
  assign bus.reverseReq   = reverseReqQ;
  assign bus.phase        = phaseQ;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Bench for ghost_mode_ctrl: expected output-change events are queued with hand-computed
// cycle numbers; a negedge monitor pops one entry whenever the output vector changes.
module tb_ghost_mode_ctrl;

  logic clk;
  logic reset_n;
  int   cyc;
  int   total;
  int   bad;
  logic monEn;
  logic [7:0] prevVec;

  typedef struct {
    int         atCyc;
    logic [7:0] vec;
  } expEvent_t;

  expEvent_t expQ[$];

  ghost_mode_ctrl_if bus ();

  ghost_mode_ctrl #(
    .SEC_TICKS(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] outVec();
    return {bus.isScatter, bus.isChase, bus.isFrightened, bus.isFlashing,
            bus.reverseReq, bus.phase};
  endfunction

  // Every change of the output vector must match the next queued event, in value and cycle.
  always @(negedge clk) begin
    logic [7:0] curVec;
    expEvent_t  e;
    curVec = outVec();
    if (monEn && curVec !== prevVec) begin
      total = total + 1;
      if (expQ.size() == 0) begin
        bad = bad + 1;
        $display("[TB] FAIL unexpectedChange cyc=%0d got=%b wanted no change", cyc, curVec);
      end else begin
        e = expQ.pop_front();
        if (e.atCyc != cyc || e.vec !== curVec) begin
          bad = bad + 1;
          $display("[TB] FAIL outputEvent got cyc=%0d vec=%b wanted cyc=%0d vec=%b",
                   cyc, curVec, e.atCyc, e.vec);
        end
      end
    end
    prevVec = curVec;
  end

  task automatic checkOutput(input string name, input int actual, input int wanted);
    total = total + 1;
    if (actual != wanted) begin
      bad = bad + 1;
      $display("[TB] FAIL %s got=%0d wanted=%0d", name, actual, wanted);
    end
  endtask

  task automatic waitTo(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushExp(input int c, input logic sc, input logic ch, input logic fr,
                         input logic fl, input logic rv, input logic [2:0] ph);
    expEvent_t e;
    e.atCyc = c;
    e.vec   = {sc, ch, fr, fl, rv, ph};
    expQ.push_back(e);
  endtask

  // Pulses energizer and/or levelRestart so the DUT samples them on edge atCyc.
  task automatic applyStimulus(input int atCyc, input logic en, input logic lr);
    waitTo(atCyc - 1);
    bus.energizer    = en;
    bus.levelRestart = lr;
    waitTo(atCyc);
    bus.energizer    = 1'b0;
    bus.levelRestart = 1'b0;
  endtask

  task automatic applyReset();
    monEn            = 1'b0;
    reset_n          = 1'b0;
    bus.start        = 1'b0;
    bus.freeze       = 1'b0;
    bus.energizer    = 1'b0;
    bus.levelRestart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetState", int'(outVec()), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    monEn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives start high; returns the cycle on which RUN is entered.
  task automatic startGame(output int t);
    bus.start = 1'b1;
    t = cyc + 1;
  endtask

  initial begin
    int t;
    int bnd[7];
    cyc     = 0;
    total   = 0;
    bad     = 0;
    monEn   = 1'b0;
    reset_n = 1'b0;
    bnd     = '{7, 27, 34, 54, 59, 79, 84};

    // Full schedule, then 200 s of phase 7
    applyReset();
    startGame(t);
    pushExp(t, 1, 0, 0, 0, 0, 3'd0);
    for (int k = 1; k <= 7; k++) begin
      pushExp(t + 4 * bnd[k-1],     ~k[0], k[0], 0, 0, 1, 3'(k));
      pushExp(t + 4 * bnd[k-1] + 1, ~k[0], k[0], 0, 0, 0, 3'(k));
    end
    waitTo(t + 4 * 84 + 800 + 4);
    checkOutput("scheduleQueueEmpty", expQ.size(), 0);
    checkOutput("phase7Chase", int'(outVec()), 8'b0100_0111);

    // Fright in phase 1, then fright with re-energize in phase 2
    applyReset();
    startGame(t);
    pushExp(t,       1, 0, 0, 0, 0, 3'd0);
    pushExp(t + 28,  0, 1, 0, 0, 1, 3'd1);
    pushExp(t + 29,  0, 1, 0, 0, 0, 3'd1);
    pushExp(t + 42,  0, 0, 1, 0, 1, 3'd1);
    pushExp(t + 43,  0, 0, 1, 0, 0, 3'd1);
    pushExp(t + 58,  0, 0, 1, 1, 0, 3'd1);
    pushExp(t + 66,  0, 1, 0, 0, 0, 3'd1);
    pushExp(t + 134, 1, 0, 0, 0, 1, 3'd2);
    pushExp(t + 135, 1, 0, 0, 0, 0, 3'd2);
    pushExp(t + 144, 0, 0, 1, 0, 1, 3'd2);
    pushExp(t + 145, 0, 0, 1, 0, 0, 3'd2);
    pushExp(t + 160, 0, 0, 1, 1, 0, 3'd2);
    pushExp(t + 166, 0, 0, 1, 0, 0, 3'd2);
    pushExp(t + 182, 0, 0, 1, 1, 0, 3'd2);
    pushExp(t + 190, 1, 0, 0, 0, 0, 3'd2);
    pushExp(t + 210, 0, 1, 0, 0, 1, 3'd3);
    pushExp(t + 211, 0, 1, 0, 0, 0, 3'd3);
    applyStimulus(t + 42, 1'b1, 1'b0);
    applyStimulus(t + 144, 1'b1, 1'b0);
    applyStimulus(t + 166, 1'b1, 1'b0);
    waitTo(t + 230);
    checkOutput("frightQueueEmpty", expQ.size(), 0);

    // Freeze for 40 edges in phase 0 with an ignored energizer
    applyReset();
    startGame(t);
    pushExp(t,      1, 0, 0, 0, 0, 3'd0);
    pushExp(t + 68, 0, 1, 0, 0, 1, 3'd1);
    pushExp(t + 69, 0, 1, 0, 0, 0, 3'd1);
    waitTo(t + 9);
    bus.freeze = 1'b1;
    applyStimulus(t + 20, 1'b1, 1'b0);
    waitTo(t + 49);
    bus.freeze = 1'b0;
    waitTo(t + 80);
    checkOutput("freezeQueueEmpty", expQ.size(), 0);

    // levelRestart beats energizer; async reset mid-fright
    applyReset();
    startGame(t);
    pushExp(t,      1, 0, 0, 0, 0, 3'd0);
    pushExp(t + 6,  0, 0, 1, 0, 1, 3'd0);
    pushExp(t + 7,  0, 0, 1, 0, 0, 3'd0);
    pushExp(t + 12, 1, 0, 0, 0, 0, 3'd0);
    pushExp(t + 40, 0, 1, 0, 0, 1, 3'd1);
    pushExp(t + 41, 0, 1, 0, 0, 0, 3'd1);
    pushExp(t + 45, 0, 0, 1, 0, 1, 3'd1);
    pushExp(t + 46, 0, 0, 1, 0, 0, 3'd1);
    applyStimulus(t + 6, 1'b1, 1'b0);
    applyStimulus(t + 12, 1'b1, 1'b1);
    applyStimulus(t + 45, 1'b1, 1'b0);
    waitTo(t + 50);
    checkOutput("restartQueueEmpty", expQ.size(), 0);
    checkOutput("midFrightBeforeReset", int'(bus.isFrightened), 1);
    monEn = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncResetOutputs", int'(outVec()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
